ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the single-port, sync-write / async-read RAM (we/oe strobes, high-Z read bus).
- Takes one burst command (base address, length, direction) and drives the RAM address, data and strobes.
- Write data enters on a valid/ready stream; read data leaves on a registered valid/ready stream.
- Sits between datapath clients and the RAM instance; it is the only driver of the RAM control pins.

Parameters:
p_data_width, 8, RAM word width
p_address_width, 20, RAM address width
p_len_width, 8, burst length field width (max burst 2**p_len_width-1 words)

Ports:
i_w_clk  in  1  clock; all state changes on posedge
i_w_rst_n  in  1  reset, synchronous, active-low
i_w_start  in  1  command strobe; accepted when o_w_cmd_ready=1
i_w_rw  in  1  1=write burst, 0=read burst
i_w_base_addr  in  p_address_width  first word address
i_w_len  in  p_len_width  word count
o_w_cmd_ready  out  1  IDLE and o_w_rvalid=0
o_w_busy  out  1  state != IDLE
o_w_done  out  1  one-cycle pulse at burst completion
i_w_wdata  in  p_data_width  write stream data
i_w_wvalid  in  1  write stream valid
o_w_wready  out  1  write stream ready
o_w_rdata  out  p_data_width  read stream data (registered)
o_w_rvalid  out  1  read stream valid
i_w_rready  in  1  read stream ready
o_w_ram_address  out  p_address_width  RAM address
o_w_ram_din  out  p_data_width  RAM write data
o_w_ram_we  out  1  RAM write enable
o_w_ram_oe  out  1  RAM output enable
i_w_ram_dout  in  p_data_width  RAM read bus (high-Z when oe=0)

Behaviour:
- FSM states: IDLE, WRITE, READ, DONE.
- Reset (i_w_rst_n=0 at posedge) forces IDLE from any state, including mid-burst.
  - Outputs after reset: o_w_busy, o_w_done, o_w_rvalid, o_w_ram_we and o_w_ram_oe are 0.
  - o_w_rdata, o_w_ram_address and the internal address/count registers are 0.
  - No partial-burst state survives reset.
- IDLE:
  - Accept when i_w_start=1 and o_w_cmd_ready=1: latch address and count.
  - len=0 -> DONE; no RAM access.
  - Otherwise rw=1 -> WRITE, rw=0 -> READ.
  - i_w_start is ignored whenever o_w_cmd_ready=0.
- WRITE:
  - o_w_wready=1.
  - o_w_ram_we = i_w_wvalid (combinational); o_w_ram_din = i_w_wdata; o_w_ram_address = current address.
  - On each posedge with wvalid=1: address+1, count-1.
  - Last word -> DONE.
  - wvalid=0 stalls the burst: we=0, no advance.
- READ:
  - o_w_ram_oe=1 for the whole state; o_w_ram_address = current address.
  - Capture condition: o_w_rvalid=0 or i_w_rready=1.
  - On each posedge meeting the capture condition: o_w_rdata <= i_w_ram_dout, o_w_rvalid <= 1, address+1, count-1.
  - Last capture -> DONE.
  - Otherwise the address is held and no capture occurs.
- o_w_rvalid clears on a posedge with i_w_rready=1 when no new capture occurs; it may remain set after READ exits.
- DONE: o_w_done=1 for exactly one cycle, then IDLE. we=0, oe=0.
- Strobe interlock: o_w_ram_we and o_w_ram_oe are never 1 together.
  - Both are 0 in IDLE and DONE, which guarantees at least one turnaround cycle between bursts.
- Address wraps modulo 2**p_address_width; all-ones + 1 = 0.
- Latency:
  - Command accepted at edge N; first RAM access in cycle N+1.
  - Read: data captured at the end of cycle N+1; o_w_rvalid=1 in N+2.
  - Full-throughput read: one word per cycle.
  - Burst of L words with no stalls: o_w_done in cycle N+1+L.
- The stream-side outputs o_w_wready and o_w_ram_din are don't-care outside WRITE; o_w_wready=0 outside WRITE.

Optional Feature:
- Macro: RAM_BURST_MASTER_CHECKSUM_EN.
- Defined:
  - Adds output o_w_checksum, width p_data_width: the XOR of every word transferred in the last burst.
    - Write bursts: the words written. Read bursts: the words captured.
  - The accumulator clears on command accept and on reset.
  - o_w_checksum is valid while o_w_done=1 and holds until the next accept.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Write burst: base=0x00010, len=4, wdata AA,BB,CC,DD with wvalid held 1 -> we high 4 consecutive cycles at 0x10..0x13; done in cycle N+5.
2. Read-back: base=0x00010, len=4, rready=1 -> rdata AA,BB,CC,DD on consecutive cycles; oe=1 exactly 4 cycles; we=0 throughout.
3. Backpressure: read len=3 with rready=0 for 2 cycles after the first word -> first word held stable, address held, no word lost or duplicated; write with wvalid gaps -> we=0 during gaps.
4. Wrap and zero length: write base=0xFFFFE, len=3 -> addresses FFFFE, FFFFF, 00000; len=0 -> done pulse one cycle after accept, no we/oe activity.
5. Reset: rst_n=0 during the 2nd word of a len=8 write -> next cycle IDLE, we=oe=0, busy=0; a new read burst then completes normally.
6. Checksum (macro defined): write 0x0F,0xF0,0x33 -> o_w_checksum=0xCC at done; reading the same 3 words back -> 0xCC.

Source files
------------

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for a single-port sync-write / async-read RAM.
// Define RAM_BURST_MASTER_CHECKSUM_EN to add o_w_checksum (XOR of the last burst's words).
module ram_burst_master #(
  parameter int unsigned p_data_width    = 8,
  parameter int unsigned p_address_width = 20,
  parameter int unsigned p_len_width     = 8
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_rst_n,
  input  logic                       i_w_start,
  input  logic                       i_w_rw,
  input  logic [p_address_width-1:0] i_w_base_addr,
  input  logic [p_len_width-1:0]     i_w_len,
  output logic                       o_w_cmd_ready,
  output logic                       o_w_busy,
  output logic                       o_w_done,
  input  logic [p_data_width-1:0]    i_w_wdata,
  input  logic                       i_w_wvalid,
  output logic                       o_w_wready,
  output logic [p_data_width-1:0]    o_w_rdata,
  output logic                       o_w_rvalid,
  input  logic                       i_w_rready,
  output logic [p_address_width-1:0] o_w_ram_address,
  output logic [p_data_width-1:0]    o_w_ram_din,
  output logic                       o_w_ram_we,
  output logic                       o_w_ram_oe,
  input  logic [p_data_width-1:0]    i_w_ram_dout
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  ,
  output logic [p_data_width-1:0]    o_w_checksum
`endif
);

  localparam int unsigned AW = p_address_width;
  localparam int unsigned LW = p_len_width;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state;
  logic [LW-1:0]   count;
  logic            accept;
  logic            capture;

  assign o_w_cmd_ready = (state == IDLE) && !o_w_rvalid;
  assign accept        = i_w_start && o_w_cmd_ready;
  // A read word is taken whenever the output register is empty or being drained.
  assign capture       = o_w_ram_oe && (!o_w_rvalid || i_w_rready);
  assign o_w_ram_we    = o_w_wready && i_w_wvalid;
  assign o_w_ram_din   = i_w_wdata;

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      state           <= IDLE;
      count           <= '0;
      o_w_ram_address <= '0;
      o_w_rdata       <= '0;
      o_w_rvalid      <= 1'b0;
      o_w_busy        <= 1'b0;
      o_w_done        <= 1'b0;
      o_w_wready      <= 1'b0;
      o_w_ram_oe      <= 1'b0;
    end else begin
      if (o_w_rvalid && i_w_rready) o_w_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o_w_ram_address <= i_w_base_addr;
            count           <= i_w_len;
            o_w_busy        <= 1'b1;
            if (i_w_len == '0) begin
              state    <= DONE;
              o_w_done <= 1'b1;
            end else if (i_w_rw) begin
              state      <= WRITE;
              o_w_wready <= 1'b1;
            end else begin
              state      <= READ;
              o_w_ram_oe <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (i_w_wvalid) begin
            o_w_ram_address <= o_w_ram_address + AW'(1);
            count           <= count - LW'(1);
            if (count == LW'(1)) begin
              state      <= DONE;
              o_w_wready <= 1'b0;
              o_w_done   <= 1'b1;
            end
          end
        end
        READ: begin
          if (capture) begin
            o_w_rdata       <= i_w_ram_dout;
            o_w_rvalid      <= 1'b1;
            o_w_ram_address <= o_w_ram_address + AW'(1);
            count           <= count - LW'(1);
            if (count == LW'(1)) begin
              state      <= DONE;
              o_w_ram_oe <= 1'b0;
              o_w_done   <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          o_w_busy <= 1'b0;
          o_w_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_w_busy   <= 1'b0;
          o_w_done   <= 1'b0;
          o_w_wready <= 1'b0;
          o_w_ram_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  // Running XOR of every word moved since the last accepted command.
  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n)       o_w_checksum <= '0;
    else if (accept)      o_w_checksum <= '0;
    else if (o_w_ram_we)  o_w_checksum <= o_w_checksum ^ i_w_wdata;
    else if (capture)     o_w_checksum <= o_w_checksum ^ i_w_ram_dout;
  end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master: stimulus pushes expected RAM writes, read words and done cycles.
`timescale 1ns/1ps
module tb_ram_burst_master;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 20;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, rw, cmd_ready, busy, done;
  logic [AW-1:0] cmd_base, ram_address;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdata, rdata, ram_din, ram_dout;
  logic          wvalid, wready, rvalid, rready, ram_we, ram_oe;
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_burst_master dut (
    .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_start(start), .i_w_rw(rw),
    .i_w_base_addr(cmd_base), .i_w_len(cmd_len), .o_w_cmd_ready(cmd_ready),
    .o_w_busy(busy), .o_w_done(done), .i_w_wdata(wdata), .i_w_wvalid(wvalid),
    .o_w_wready(wready), .o_w_rdata(rdata), .o_w_rvalid(rvalid), .i_w_rready(rready),
    .o_w_ram_address(ram_address), .o_w_ram_din(ram_din), .o_w_ram_we(ram_we),
    .o_w_ram_oe(ram_oe), .i_w_ram_dout(ram_dout)
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    , .o_w_checksum(checksum)
`endif
  );

  // RAM model indexed by the low address byte; a floating bus reads as 0xEE.
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (ram_we) mem[ram_address[7:0]] <= ram_din;
  assign ram_dout = ram_oe ? mem[ram_address[7:0]] : 8'hEE;

  logic [AW+DW-1:0] wr_exp[$];
  logic [DW-1:0]    rd_exp[$];
  int               done_exp[$];
  int compared = 0, mism = 0, cyc = 0, we_cnt = 0, oe_cnt = 0;
  logic mon_en = 1'b0;
  logic ck_en = 1'b0;
  logic [DW-1:0] ck_exp = '0;
  logic [DW-1:0] wbuf [8];
  logic [DW-1:0] rbuf [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] got);
    compared++;
    mism++;
    $display("FAIL %s: got %0h, nothing expected (cycle %0d)", name, got, cyc);
  endtask

  // Monitor: compare every RAM write, read handshake and done pulse against the queues.
  always @(negedge clk) if (mon_en) begin
    chk("interlock", 32'(ram_we & ram_oe), 32'd0);
    if (ram_oe) oe_cnt++;
    if (ram_we) begin
      we_cnt++;
      if (wr_exp.size() == 0) flag("unexpected_write", 32'({ram_address, ram_din}));
      else chk("ram_write", 32'({ram_address, ram_din}), 32'(wr_exp.pop_front()));
    end
    if (rvalid && rready) begin
      if (rd_exp.size() == 0) flag("unexpected_rdata", 32'(rdata));
      else chk("rdata", 32'(rdata), 32'(rd_exp.pop_front()));
    end
    if (done) begin
      if (done_exp.size() == 0) flag("unexpected_done", 32'(cyc));
      else chk("done_cycle", 32'(cyc), 32'(done_exp.pop_front()));
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 40 && !cmd_ready; k++) begin @(posedge clk); #1; end
    if (!cmd_ready) flag("idle_timeout", 32'(cmd_ready));
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 40) flag("done_timeout", 32'(done));
`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    else if (ck_en) chk("checksum", 32'(checksum), 32'(ck_exp));
`endif
    @(posedge clk); #1;
  endtask

  // Present one command; lat = cycles from the accept edge to the done cycle's edge count.
  task automatic issue(input logic rw_i, input logic [AW-1:0] b, input logic [LW-1:0] l, input int lat);
    wait_idle();
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    start = 1'b1; rw = rw_i; cmd_base = b; cmd_len = l;
    @(posedge clk); #1;
    start = 1'b0;
    done_exp.push_back(cyc + lat);
  endtask

  task automatic write_burst(input logic [AW-1:0] b, input int l, input int lat, input logic [15:0] gaps);
    int idx = 0;
    issue(1'b1, b, LW'(l), lat);
    for (int c = 0; idx < l && c < 16; c++) begin
      if (gaps[c]) wvalid = 1'b0;
      else begin
        wvalid = 1'b1;
        wdata  = wbuf[idx];
        wr_exp.push_back({b + AW'(idx), wbuf[idx]});
        idx++;
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wait_done();
  endtask

  task automatic read_burst(input logic [AW-1:0] b, input int l, input int lat);
    rready = 1'b1;
    for (int i = 0; i < l; i++) rd_exp.push_back(rbuf[i]);
    issue(1'b0, b, LW'(l), lat);
    wait_done();
  endtask

  initial begin
    int we0, oe0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; cmd_base = '0; cmd_len = '0;
    wdata = '0; wvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);     chk("rst_done", 32'(done), 0);
    chk("rst_rvalid", 32'(rvalid), 0); chk("rst_we", 32'(ram_we), 0);
    chk("rst_oe", 32'(ram_oe), 0);     chk("rst_rdata", 32'(rdata), 0);
    chk("rst_addr", 32'(ram_address), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Straight write then read-back.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
    we0 = we_cnt;
    write_burst(20'h00010, 4, 4, 16'h0);
    chk("wr_we_cycles", 32'(we_cnt - we0), 32'd4);
    rbuf[0] = 8'hAA; rbuf[1] = 8'hBB; rbuf[2] = 8'hCC; rbuf[3] = 8'hDD;
    we0 = we_cnt; oe0 = oe_cnt;
    read_burst(20'h00010, 4, 4);
    chk("rd_oe_cycles", 32'(oe_cnt - oe0), 32'd4);
    chk("rd_we_cycles", 32'(we_cnt - we0), 32'd0);

    // Read backpressure: two stalled cycles after the first word.
    rready = 1'b1;
    rd_exp.push_back(8'hAA); rd_exp.push_back(8'hBB); rd_exp.push_back(8'hCC);
    issue(1'b0, 20'h00010, 8'd3, 5);
    @(posedge clk); #1;
    rready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("stall_rdata", 32'(rdata), 32'hAA);
      chk("stall_rvalid", 32'(rvalid), 32'd1);
      chk("stall_addr", 32'(ram_address), 32'h00011);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    wait_done();

    // Write with wvalid gaps on the 2nd and 4th cycles.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    we0 = we_cnt;
    write_burst(20'h00020, 3, 5, 16'b1010);
    chk("gap_we_cycles", 32'(we_cnt - we0), 32'd3);

    // Address wrap, then read across the wrap.
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
    write_burst(20'hFFFFE, 3, 3, 16'h0);
    rbuf[0] = 8'h02; rbuf[1] = 8'h03;
    read_burst(20'hFFFFF, 2, 2);

    // Zero-length bursts: done one cycle after accept, no strobes.
    we0 = we_cnt; oe0 = oe_cnt;
    write_burst(20'h00030, 0, 0, 16'h0);
    read_burst(20'h00030, 0, 0);
    chk("len0_we", 32'(we_cnt - we0), 32'd0);
    chk("len0_oe", 32'(oe_cnt - oe0), 32'd0);

    // Reset during the second word of a len=8 write.
    wait_idle();
    issue(1'b1, 20'h00040, 8'd8, 0);
    void'(done_exp.pop_back());
    wvalid = 1'b1; wdata = 8'h5A; wr_exp.push_back({20'h00040, 8'h5A});
    @(posedge clk); #1;
    wdata = 8'hA5; wr_exp.push_back({20'h00041, 8'hA5});
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(ram_we), 0);
    chk("mid_rst_oe", 32'(ram_oe), 0);
    chk("mid_rst_addr", 32'(ram_address), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; wvalid = 1'b0;
    rbuf[0] = 8'h5A; rbuf[1] = 8'hA5;
    read_burst(20'h00040, 2, 2);

`ifdef RAM_BURST_MASTER_CHECKSUM_EN
    ck_en = 1'b1; ck_exp = 8'hCC;
    wbuf[0] = 8'h0F; wbuf[1] = 8'hF0; wbuf[2] = 8'h33;
    write_burst(20'h00050, 3, 3, 16'h0);
    rbuf[0] = 8'h0F; rbuf[1] = 8'hF0; rbuf[2] = 8'h33;
    read_burst(20'h00050, 3, 3);
    ck_en = 1'b0;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("wr_exp_left", 32'(wr_exp.size()), 0);
    chk("rd_exp_left", 32'(rd_exp.size()), 0);
    chk("done_exp_left", 32'(done_exp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
